// File: rtl/tdc_therm_decoder.sv
// rtl/tdc_therm_decoder.sv - TDC thermometer capture, bubble correction and first-edge encoder
// Optional averaging output stage enabled by defining TDC_AVG_EN.
module tdc_therm_decoder #(
  parameter int N_TAPS   = 16,
  parameter int AVG_LOG2 = 2,
  localparam int CW      = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_TAPS-1:0] samp_i,
  input  logic              samp_vld_i,
  output logic [CW-1:0]     code_o,
  output logic              pol_o,
  output logic              no_edge_o,
  output logic              vld_o
);

  logic [N_TAPS-1:0] r_t1;
  logic              r_v1;
  logic [N_TAPS-1:0] r_t2;
  logic              r_v2;
  logic [N_TAPS-1:0] w_t2;
  logic [CW-1:0]     w_k;
  logic              w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= '0;
      r_v1 <= 1'b0;
      r_t2 <= '0;
      r_v2 <= 1'b0;
    end else begin
      if (samp_vld_i && en) begin
        r_t1 <= samp_i;
        r_v1 <= 1'b1;
      end else begin
        r_v1 <= 1'b0;
      end
      r_t2 <= w_t2;
      r_v2 <= r_v1;
    end
  end

  // 3-tap majority vote removes single-bit bubbles; end taps have no neighbour pair.
  always_comb begin
    w_t2 = r_t1;
    for (int i = 1; i <= N_TAPS - 2; i++) begin
      w_t2[i] = (r_t1[i-1] & r_t1[i]) | (r_t1[i-1] & r_t1[i+1]) | (r_t1[i] & r_t1[i+1]);
    end
  end

  // Scan downward so the lowest transition is the one left standing.
  always_comb begin
    w_k     = '0;
    w_found = 1'b0;
    for (int k = N_TAPS - 1; k >= 1; k--) begin
      if (r_t2[k] != r_t2[k-1]) begin
        w_k     = CW'(k);
        w_found = 1'b1;
      end
    end
  end

`ifdef TDC_AVG_EN
  logic [CW-1:0]          r_k3;
  logic                   r_pol3;
  logic                   r_ne3;
  logic                   r_v3;
  logic [CW+AVG_LOG2-1:0] r_acc;
  logic [AVG_LOG2-1:0]    r_cnt;
  logic                   r_pol_acc;
  logic [CW+AVG_LOG2-1:0] w_sum;

  assign w_sum = r_acc + {{AVG_LOG2{1'b0}}, r_k3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k3      <= '0;
      r_pol3    <= 1'b0;
      r_ne3     <= 1'b0;
      r_v3      <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pol_acc <= 1'b0;
      code_o    <= '0;
      pol_o     <= 1'b0;
      no_edge_o <= 1'b0;
      vld_o     <= 1'b0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_k3   <= w_k;
        r_pol3 <= r_t2[0];
        r_ne3  <= ~w_found;
      end
      vld_o     <= 1'b0;
      no_edge_o <= r_v3 & r_ne3;
      if (!en) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_v3 && !r_ne3) begin
        r_pol_acc <= r_pol3;
        if (r_cnt == {AVG_LOG2{1'b1}}) begin
          code_o <= w_sum[CW+AVG_LOG2-1:AVG_LOG2];
          pol_o  <= r_pol3;
          vld_o  <= 1'b1;
          r_acc  <= '0;
          r_cnt  <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_o    <= '0;
      pol_o     <= 1'b0;
      no_edge_o <= 1'b0;
      vld_o     <= 1'b0;
    end else begin
      vld_o <= r_v2;
      if (r_v2) begin
        code_o    <= w_k;
        pol_o     <= r_t2[0];
        no_edge_o <= ~w_found;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// tb/tb_tdc_therm_decoder.sv - directed bench for tdc_therm_decoder, N_TAPS=16 default build
module tb_tdc_therm_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] samp_i;
  logic        samp_vld_i;
  logic [3:0]  code_o;
  logic        pol_o;
  logic        no_edge_o;
  logic        vld_o;

  int checks = 0;
  int errors = 0;

  tdc_therm_decoder #(.N_TAPS(16), .AVG_LOG2(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .samp_i     (samp_i),
    .samp_vld_i (samp_vld_i),
    .code_o     (code_o),
    .pol_o      (pol_o),
    .no_edge_o  (no_edge_o),
    .vld_o      (vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                           input logic p, input logic ne);
    check({tag, ".vld"},  {31'd0, vld_o},     {31'd0, v});
    check({tag, ".code"}, {28'd0, code_o},    {28'd0, c});
    check({tag, ".pol"},  {31'd0, pol_o},     {31'd0, p});
    check({tag, ".ne"},   {31'd0, no_edge_o}, {31'd0, ne});
  endtask

  // One strobe, then confirm nothing appears before the third edge.
  task automatic send(input string tag, input logic [15:0] d, input logic [3:0] c,
                      input logic p, input logic ne);
    samp_i     = d;
    samp_vld_i = 1'b1;
    step();
    samp_vld_i = 1'b0;
    step();
    check({tag, ".early"}, {31'd0, vld_o}, 32'd0);
    step();
    check_out(tag, 1'b1, c, p, ne);
    step();
    check({tag, ".pulse"}, {31'd0, vld_o}, 32'd0);
    check({tag, ".hold"}, {28'd0, code_o}, {28'd0, c});
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    samp_i     = '0;
    samp_vld_i = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    en    = 1'b1;
    step();
    send("s00ff", 16'h00FF, 4'd8, 1'b1, 1'b0);
    send("s00f7", 16'h00F7, 4'd8, 1'b1, 1'b0);
    send("sff08", 16'hFF08, 4'd8, 1'b0, 1'b0);
    send("s0000", 16'h0000, 4'd0, 1'b0, 1'b1);
    send("sffff", 16'hFFFF, 4'd0, 1'b1, 1'b1);
    send("s7fff", 16'h7FFF, 4'd15, 1'b1, 1'b0);

    samp_i     = 16'h0003;
    samp_vld_i = 1'b1;
    step();
    samp_i = 16'h000F;
    step();
    samp_i = 16'h003F;
    step();
    check_out("b2b0", 1'b1, 4'd2, 1'b1, 1'b0);
    en     = 1'b0;
    samp_i = 16'h00FF;
    step();
    check_out("b2b1", 1'b1, 4'd4, 1'b1, 1'b0);
    step();
    check_out("b2b2", 1'b1, 4'd6, 1'b1, 1'b0);
    step();
    check("en_off0", {31'd0, vld_o}, 32'd0);
    step();
    check("en_off1", {31'd0, vld_o}, 32'd0);
    check("en_hold", {28'd0, code_o}, 32'd6);

    en         = 1'b1;
    samp_i     = 16'h00FF;
    samp_vld_i = 1'b1;
    step();
    samp_vld_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_out("midrst", 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst", {31'd0, vld_o}, 32'd0);
    end
    send("recover", 16'h000F, 4'd4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
